// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if: requester-side and serdes-side bundles for tx_arbiter.
interface tx_arbiter_req_if #(
    parameter int NSHIFT      = 2,
    parameter int TX_CMD_BITS = 2
);
    logic                   cmd_valid;
    logic [TX_CMD_BITS-1:0] cmd;
    logic                   reply_wanted;
    logic [NSHIFT-1:0]      data;
    logic                   started;
    logic                   data_next;
    logic                   tx_done;
    logic                   rx_data_valid;
    logic                   rx_done;
    modport master (
        output cmd_valid, cmd, reply_wanted, data,
        input  started, data_next, tx_done, rx_data_valid, rx_done
    );
    modport slave (
        input  cmd_valid, cmd, reply_wanted, data,
        output started, data_next, tx_done, rx_data_valid, rx_done
    );
endinterface

interface tx_arbiter_tx_if #(
    parameter int NSHIFT      = 2,
    parameter int TX_CMD_BITS = 2
);
    logic                   tx_command_valid;
    logic [TX_CMD_BITS-1:0] tx_command;
    logic                   tx_reply_wanted;
    logic [NSHIFT-1:0]      tx_data;
    logic                   tx_command_started;
    logic                   tx_data_next;
    logic                   tx_done;
    logic                   rx_data_valid;
    logic                   rx_done;
    modport master (
        output tx_command_valid, tx_command, tx_reply_wanted, tx_data,
        input  tx_command_started, tx_data_next, tx_done, rx_data_valid, rx_done
    );
    modport slave (
        input  tx_command_valid, tx_command, tx_reply_wanted, tx_data,
        output tx_command_started, tx_data_next, tx_done, rx_data_valid, rx_done
    );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares the serial TX command channel between prefetch (pf) and scheduler (sc), routing RX replies in order.
module tx_arbiter #(
    parameter int NSHIFT          = 2,
    parameter int TX_CMD_BITS     = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sc_reserve,
    tx_arbiter_req_if.slave pf,
    tx_arbiter_req_if.slave sc,
    tx_arbiter_tx_if.master tx,
    output logic            reply_underflow
);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        r_state, w_next;
    logic          r_owner, r_last, r_underflow;
    logic          r_fifo [MAX_OUTSTANDING];
    logic [PW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_count;
    logic          w_cand, w_cand_valid, w_sel, w_valid, w_start, w_push, w_pop;
    logic          w_empty, w_head, w_busy, w_rw;

    // owner encoding: 0 = pf, 1 = sc
    always_comb begin
        w_busy       = r_state == BUSY;
        w_cand       = sc_reserve | (sc.cmd_valid & (~pf.cmd_valid | ~r_last));
        w_cand_valid = w_cand ? sc.cmd_valid : pf.cmd_valid;
        w_valid      = ~w_busy & w_cand_valid & (r_count != FULL_CNT);
        w_sel        = w_busy ? r_owner : w_cand;
        w_rw         = w_sel ? sc.reply_wanted : pf.reply_wanted;
        w_start      = w_valid & tx.tx_command_started;
        w_push       = w_start & w_rw;
        w_empty      = r_count == '0;
        w_head       = r_fifo[r_rd];
        w_pop        = tx.rx_done & ~w_empty;
        w_next       = w_start ? BUSY : (w_busy & tx.tx_done) ? IDLE : r_state;
    end

    assign tx.tx_command_valid = w_valid;
    assign tx.tx_command       = w_sel ? sc.cmd : pf.cmd;
    assign tx.tx_reply_wanted  = w_rw;
    assign tx.tx_data          = w_busy ? (r_owner ? sc.data : pf.data) : '0;
    assign pf.started          = w_start & ~w_cand;
    assign sc.started          = w_start & w_cand;
    assign pf.data_next        = w_busy & ~r_owner & tx.tx_data_next;
    assign sc.data_next        = w_busy & r_owner & tx.tx_data_next;
    assign pf.tx_done          = w_busy & ~r_owner & tx.tx_done;
    assign sc.tx_done          = w_busy & r_owner & tx.tx_done;
    assign pf.rx_data_valid    = tx.rx_data_valid & ~w_empty & ~w_head;
    assign sc.rx_data_valid    = tx.rx_data_valid & ~w_empty & w_head;
    assign pf.rx_done          = tx.rx_done & ~w_empty & ~w_head;
    assign sc.rx_done          = tx.rx_done & ~w_empty & w_head;
    assign reply_underflow     = r_underflow;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner     <= 1'b0;
            r_last      <= 1'b0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_start) begin
                r_owner <= w_cand;
                r_last  <= w_cand;
            end
            if (w_push) r_wr <= r_wr == LAST_PTR ? '0 : r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd == LAST_PTR ? '0 : r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if ((tx.rx_done | tx.rx_data_valid) & w_empty) r_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr] <= w_cand;
    end
endmodule
